// File: rtl/lag_sample_scheduler.sv
// Pacing stage for the lag/echo FP64 datapath: buffers samples and
// releases one per sampling period, with strobe, enable and fault tracking.
module lag_sample_scheduler #(
    parameter int SAMPLE_DIV    = 25,
    parameter int FIFO_DEPTH    = 16,
    parameter int PRIME_SAMPLES = 4
) (
    input  logic                          clk_operation,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [63:0]                   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          lag_ready,
    output logic [63:0]                   signal,
    output logic                          sampling_cycle_counter,
    output logic                          enable_sampling,
    output logic                          enable,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_count,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int PW = $clog2(PRIME_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [PW-1:0]   prime_cnt;
    logic [63:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            active;
    logic            fifo_empty;
    logic            tick;
    logic            push;
    logic            pop;

    assign active     = (state != IDLE);
    assign fifo_empty = (fifo_level == '0);
    // stop outranks the tick, so a stop in the tick cycle pops nothing
    assign tick       = active && !stop && (div_cnt == DW'(SAMPLE_DIV - 1));
    assign in_ready   = !rst && (fifo_level < LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = tick && !fifo_empty;

    assign busy            = active;
    assign enable_sampling = active;

    always_ff @(posedge clk_operation) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state                  <= IDLE;
            div_cnt                <= '0;
            prime_cnt              <= '0;
            signal                 <= '0;
            sampling_cycle_counter <= 1'b1;
            enable                 <= 1'b0;
            underrun_count         <= '0;
            overrun                <= 1'b0;
        end else begin
            sampling_cycle_counter <= 1'b1;
            enable                 <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (start && !stop) begin
                        state          <= PRIME;
                        prime_cnt      <= '0;
                        overrun        <= 1'b0;
                        underrun_count <= '0;
                    end
                end
                PRIME, RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                    end else begin
                        // decisions taken in the strobe cycle itself
                        if (!sampling_cycle_counter) begin
                            if (state == PRIME) begin
                                prime_cnt <= prime_cnt + PW'(1);
                                if (prime_cnt == PW'(PRIME_SAMPLES - 1)) begin
                                    state  <= RUN;
                                    enable <= 1'b1;
                                end
                            end else if (lag_ready) begin
                                enable <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                        if (tick) begin
                            div_cnt <= '0;
                            if (!fifo_empty) begin
                                signal                 <= mem[rd_ptr];
                                sampling_cycle_counter <= 1'b0;
                            end else if (underrun_count != 16'hFFFF) begin
                                underrun_count <= underrun_count + 16'd1;
                            end
                        end else begin
                            div_cnt <= div_cnt + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_sample_scheduler.sv
// Bench for lag_sample_scheduler: directed scenarios plus random traffic
// compared each cycle against a queue-based timeline model.
module tb_lag_sample_scheduler;

    localparam int DIV   = 25;
    localparam int DEPTH = 16;
    localparam int NPRI  = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic        clk_operation = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        lag_ready = 1'b0;
    logic [63:0] signal;
    logic        sampling_cycle_counter;
    logic        enable_sampling;
    logic        enable;
    logic        busy;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_count;
    logic        overrun;

    always #10 clk_operation = ~clk_operation;

    lag_sample_scheduler #(
        .SAMPLE_DIV(DIV),
        .FIFO_DEPTH(DEPTH),
        .PRIME_SAMPLES(NPRI)
    ) dut (
        .clk_operation(clk_operation),
        .rst(rst),
        .start(start),
        .stop(stop),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .lag_ready(lag_ready),
        .signal(signal),
        .sampling_cycle_counter(sampling_cycle_counter),
        .enable_sampling(enable_sampling),
        .enable(enable),
        .busy(busy),
        .fifo_level(fifo_level),
        .underrun_count(underrun_count),
        .overrun(overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: edges since start, sample queue, event flags
    logic [63:0] m_q [$];
    int          m_mode = M_IDLE;
    int          m_t = 0;
    int          m_primes = 0;
    logic [63:0] m_signal = '0;
    bit          m_strobe = 0;
    bit          m_enable = 0;
    int          m_under = 0;
    bit          m_over = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit was_strobe;
        bit push_ok;
        push_ok = in_valid && (m_q.size() < DEPTH);
        if (rst) begin
            m_q.delete();
            m_mode = M_IDLE;
            m_t = 0;
            m_primes = 0;
            m_signal = '0;
            m_strobe = 0;
            m_enable = 0;
            m_under = 0;
            m_over = 0;
            return;
        end
        was_strobe = m_strobe;
        m_strobe = 0;
        m_enable = 0;
        if (m_mode == M_IDLE) begin
            if (start && !stop) begin
                m_mode = M_PRIME;
                m_t = 0;
                m_primes = 0;
                m_over = 0;
                m_under = 0;
            end
        end else if (stop) begin
            m_mode = M_IDLE;
        end else begin
            if (was_strobe) begin
                if (m_mode == M_PRIME) begin
                    m_primes++;
                    if (m_primes == NPRI) begin
                        m_mode = M_RUN;
                        m_enable = 1;
                    end
                end else if (lag_ready) begin
                    m_enable = 1;
                end else begin
                    m_over = 1;
                end
            end
            m_t++;
            if (m_t % DIV == 0) begin
                if (m_q.size() > 0) begin
                    m_signal = m_q.pop_front();
                    m_strobe = 1;
                end else if (m_under < 65535) begin
                    m_under++;
                end
            end
        end
        if (push_ok) m_q.push_back(in_data);
    endtask

    task automatic compare_all();
        chk("signal", signal, m_signal);
        chk("strobe_n", 64'(sampling_cycle_counter), 64'(!m_strobe));
        chk("enable", 64'(enable), 64'(m_enable));
        chk("enable_sampling", 64'(enable_sampling), 64'(m_mode != M_IDLE));
        chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
        chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        chk("underrun", 64'(underrun_count), 64'(m_under));
        chk("overrun", 64'(overrun), 64'(m_over));
        chk("in_ready", 64'(in_ready), 64'(!rst && m_q.size() < DEPTH));
    endtask

    task automatic step();
        @(posedge clk_operation);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_n(input int n, input bit real_seq);
        for (int i = 1; i <= n; i++) begin
            in_valid = 1'b1;
            in_data = real_seq ? $realtobits(real'(i)) : {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int nstrobe;
        int nen;
        int rate;
        logic [63:0] sig_keep;

        step();
        step();
        chk("reset_strobe_n", 64'(sampling_cycle_counter), 64'd1);
        chk("reset_signal", signal, 64'd0);
        rst = 1'b0;

        // in-order release and enable pulses
        push_n(6, 1);
        lag_ready = 1'b1;
        pulse_start();
        nstrobe = 0;
        nen = 0;
        for (int k = 1; k <= 160; k++) begin
            step();
            if (!sampling_cycle_counter) begin
                nstrobe++;
                chk("s1_strobe_time", 64'(k), 64'(DIV * nstrobe));
                chk("s1_value", signal, $realtobits(real'(nstrobe)));
            end
            if (enable) nen++;
        end
        chk("s1_strobes", 64'(nstrobe), 64'd6);
        chk("s1_enables", 64'(nen), 64'd3);
        chk("s1_level", 64'(fifo_level), 64'd0);
        pulse_stop();

        // underruns while priming
        push_n(2, 0);
        pulse_start();
        nen = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (enable) nen++;
        end
        chk("s2_under", 64'(underrun_count), 64'd2);
        chk("s2_enables", 64'(nen), 64'd0);
        chk("s2_busy", 64'(busy), 64'd1);
        pulse_stop();

        // fill beyond capacity in IDLE
        push_n(20, 0);
        chk("s3_level", 64'(fifo_level), 64'd16);
        pulse_start();
        for (int k = 1; k <= 25; k++) step();
        chk("s3_ready", 64'(in_ready), 64'd1);
        chk("s3_level_pop", 64'(fifo_level), 64'd15);
        pulse_stop();

        // overrun on 5th strobe
        do_reset();
        push_n(6, 0);
        lag_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 160; k++) begin
            lag_ready = (k >= 120 && k <= 130) ? 1'b0 : 1'b1;
            step();
        end
        chk("s4_overrun", 64'(overrun), 64'd1);
        pulse_stop();
        pulse_start();
        chk("s4_cleared", 64'(overrun), 64'd0);
        pulse_stop();

        // stop in the tick cycle
        push_n(3, 0);
        pulse_start();
        for (int k = 1; k <= 24; k++) step();
        sig_keep = signal;
        pulse_stop();
        chk("s5_busy", 64'(busy), 64'd0);
        nstrobe = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (!sampling_cycle_counter) nstrobe++;
        end
        chk("s5_strobes", 64'(nstrobe), 64'd0);
        chk("s5_level", 64'(fifo_level), 64'd3);
        chk("s5_signal", signal, sig_keep);

        // reset mid-RUN
        do_reset();
        push_n(9, 0);
        pulse_start();
        for (int k = 1; k <= 110; k++) step();
        chk("s6_level_pre", 64'(fifo_level), 64'd5);
        do_reset();
        chk("s6_level", 64'(fifo_level), 64'd0);
        chk("s6_signal", signal, 64'd0);
        chk("s6_busy", 64'(busy), 64'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rate = int'($urandom_range(1, 50));
            in_valid  = ($urandom % 100) < rate;
            in_data   = {$urandom, $urandom};
            lag_ready = ($urandom % 4) != 0;
            start     = ($urandom % 150) == 0;
            stop      = ($urandom % 400) == 0;
            rst       = ($urandom % 1500) == 0;
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lag_sample_scheduler.md
Name: lag_sample_scheduler

Overview:
- Upstream pacing stage for the lag/echo FP64 datapath.
- Buffers incoming FP64 samples in a FIFO and releases one sample per sampling period on `signal`.
- Generates the sampling strobe (`sampling_cycle_counter` low for one cycle) and `enable_sampling`, and issues the per-sample `enable` pulse to the lag stage.
- Tracks the lag stage's `ready` handshake, FIFO underruns and compute overruns.

Parameters:
- SAMPLE_DIV, 25, clk_operation cycles per sampling period (500ns/20ns); minimum 4.
- FIFO_DEPTH, 16, sample FIFO entries; power of two.
- PRIME_SAMPLES, 4, strobes needed to fill the lag taps before the first compute.

Ports:
- clk_operation  in  1  operation clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  leave IDLE and begin pacing (pulse)
- stop  in  1  return to IDLE (pulse); wins over start
- in_data  in  64  FP64 sample from producer
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; = !rst && fifo_level < FIFO_DEPTH (combinational)
- lag_ready  in  1  lag stage compute-done flag (level)
- signal  out  64  current sample presented to lag stage
- sampling_cycle_counter  out  1  sampling strobe, active-low one cycle per period
- enable_sampling  out  1  high while PRIME or RUN
- enable  out  1  one-cycle compute-start pulse to lag stage
- busy  out  1  high when state != IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- underrun_count  out  16  periods with empty FIFO, saturating
- overrun  out  1  sticky: sample strobed while lag stage not ready

Behaviour:
- Reset state: FIFO emptied, state IDLE, div_cnt 0, prime_cnt 0.
- Reset output values: signal 0, sampling_cycle_counter 1, enable_sampling 0, enable 0, busy 0, fifo_level 0, underrun_count 0, overrun 0.
- Reset mid-operation: all of the above take effect at the next edge; buffered data is discarded.
- FIFO:
  - Push when in_valid && in_ready, in every state.
  - Pop only on a successful tick.
  - Push and pop in the same cycle: level unchanged. Push is allowed while full only if in_ready was already low, i.e. never.
  - Pop order is first-in first-out; pointers wrap modulo FIFO_DEPTH.
- State IDLE:
  - div_cnt held at 0; sampling_cycle_counter 1; enable 0; enable_sampling 0.
  - start (without stop) -> PRIME, div_cnt 0, prime_cnt 0; overrun and underrun_count cleared.
- States PRIME and RUN:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps. The tick cycle is div_cnt == SAMPLE_DIV-1.
  - Tick with FIFO non-empty: at the edge ending the tick cycle, signal <= FIFO head, pop, and sampling_cycle_counter <= 0 for exactly one cycle (the strobe cycle).
  - Tick with FIFO empty: no pop, no strobe, signal holds, underrun_count += 1 (saturating at 16'hFFFF), and prime_cnt is not advanced.
  - First strobe occurs in the cycle after edge SAMPLE_DIV, counting the start-sampling edge as 0. Strobe period is SAMPLE_DIV cycles.
- PRIME: each strobe increments prime_cnt. On the PRIME_SAMPLES-th strobe -> RUN, and enable is pulsed unconditionally in the cycle after that strobe.
- RUN, on each subsequent strobe:
  - lag_ready sampled in the strobe cycle.
  - lag_ready == 1: enable pulses for one cycle, in the cycle after the strobe.
  - lag_ready == 0: no enable, overrun <= 1 (sticky until start or rst).
- stop in PRIME or RUN:
  - -> IDLE at the next edge; sampling_cycle_counter and enable return to inactive.
  - FIFO contents and signal retained; counters and flags retained.
- start while in PRIME or RUN is ignored.
- No two strobes closer than SAMPLE_DIV cycles; enable never asserts in IDLE or PRIME except the priming pulse.

Test Plan:
- Reset, push 6 samples 1.0..6.0 (FP64), start; hold lag_ready = 1 → strobes at cycles 25, 50, 75, 100, 125, 150 after start. signal follows 1.0..6.0 in order. One enable pulse after the 4th strobe and after each later strobe. fifo_level ends at 0.
- Push 2 samples, start, no further pushes → 2 strobes, then no strobes. underrun_count increments by 1 every 25 cycles; state stays PRIME; enable never asserts.
- Push 20 samples with continuous in_valid and no start → in_ready drops after 16 accepted; fifo_level = 16; 4 samples refused. After start and the first pop, in_ready rises again.
- RUN with lag_ready held 0 at the 5th strobe → no enable after that strobe; overrun = 1 and stays 1 after lag_ready returns. Next start from IDLE clears it.
- stop asserted in the same cycle as a tick → no further strobes, enable stays 0, busy = 0 next cycle. signal and fifo_level retain their values.
- rst asserted for 1 cycle mid-RUN with 5 samples buffered → next cycle: fifo_level 0, signal 0, sampling_cycle_counter 1, busy 0, underrun_count 0, overrun 0.
